// File: rtl/lsu_pkg.sv
// Shared types, Funct3 encodings and size/alignment helpers for the load/store unit.
// LSU_MISALIGN_TRAP_EN adds the ERR state used to trap misaligned accesses.
package lsu_pkg;

  localparam int LSU_DATA_WIDTH = 32;
  localparam int LSU_ADDR_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

`ifdef LSU_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} lsu_state_e;
`else
  typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_e;
`endif

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  // Reserved encodings fall through to a plain word access.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic f3_zext(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] a);
    return ((size == SZ_H) && a[0]) || ((size == SZ_W) && (a != 2'b00));
  endfunction

  function automatic logic [1:0] align_offset(input lsu_size_e size, input logic [1:0] a);
    case (size)
      SZ_H:    return {a[1], 1'b0};
      SZ_W:    return 2'b00;
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane steering / byte-enable generation and load extraction / extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  lsu_size_e             st_size,
  input  logic [1:0]            st_offset,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic [BE_WIDTH-1:0]   st_be,
  output logic [DATA_WIDTH-1:0] st_wdata,
  input  lsu_size_e             ld_size,
  input  logic [1:0]            ld_offset,
  input  logic                  ld_zext,
  input  logic [DATA_WIDTH-1:0] ld_rdata,
  output logic [DATA_WIDTH-1:0] ld_data
);

  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    st_be    = '1;
    st_wdata = st_data;
    case (st_size)
      SZ_B: begin
        st_be    = BE_WIDTH'(1) << st_offset;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_be    = st_offset[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = ld_rdata >> {ld_offset, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (ld_size)
      SZ_B:    ld_data = {{(DATA_WIDTH-8){~ld_zext & shifted[7]}}, shifted[7:0]};
      SZ_H:    ld_data = {{(DATA_WIDTH-16){~ld_zext & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one word-aligned req/ack bus transaction per load or store.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  Stall,
  output logic                  LoadValid,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  MisalignErr,
  output logic                  BusReq,
  output logic                  BusWE,
  output logic [ADDR_WIDTH-1:0] BusAddr,
  output logic [BE_WIDTH-1:0]   BusBE,
  output logic [DATA_WIDTH-1:0] BusWData,
  input  logic                  BusAck,
  input  logic [DATA_WIDTH-1:0] BusRData
);

  lsu_state_e            state_q, state_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [BE_WIDTH-1:0]   bus_be_q, bus_be_d;
  logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  load_valid_q, load_valid_d;
  logic                  misalign_err_q, misalign_err_d;
  lsu_size_e             size_q, size_d;
  logic [1:0]            offset_q, offset_d;
  logic                  zext_q, zext_d;

  logic                  req, trap, launch;
  lsu_size_e             acc_size;
  logic [1:0]            acc_offset;
  logic [BE_WIDTH-1:0]   st_be;
  logic [DATA_WIDTH-1:0] st_wdata, ld_data;

  assign req      = MemRead | MemWrite;
  assign acc_size = f3_size(Funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  assign acc_offset = ALUResult[1:0];
  assign trap       = req & is_misaligned(acc_size, ALUResult[1:0]);
`else
  assign acc_offset = align_offset(acc_size, ALUResult[1:0]);
  assign trap       = 1'b0;
`endif
  assign launch = req & ~trap;

  lsu_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .BE_WIDTH   (BE_WIDTH)
  ) u_align (
    .st_size   (acc_size),
    .st_offset (acc_offset),
    .st_data   (WriteData),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_size   (size_q),
    .ld_offset (offset_q),
    .ld_zext   (zext_q),
    .ld_rdata  (BusRData),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d        = state_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_be_d       = bus_be_q;
    bus_wdata_d    = bus_wdata_q;
    read_data_d    = read_data_q;
    size_d         = size_q;
    offset_d       = offset_q;
    zext_d         = zext_q;
    load_valid_d   = 1'b0;
    misalign_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d     = REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = ~MemRead;
          bus_addr_d  = {ALUResult[ADDR_WIDTH-1:2], 2'b00};
          bus_be_d    = st_be;
          bus_wdata_d = st_wdata;
          size_d      = acc_size;
          offset_d    = acc_offset;
          zext_d      = f3_zext(Funct3);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if (trap) begin
          state_d        = ERR;
          misalign_err_d = 1'b1;
        end
`endif
      end
      REQ: begin
        if (BusAck) begin
          state_d      = RESP;
          bus_req_d    = 1'b0;
          load_valid_d = ~bus_we_q;
          if (!bus_we_q) read_data_d = ld_data;
        end
      end
      // RESP and ERR both last exactly one cycle; the held request is dropped.
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_be_q       <= '0;
      bus_wdata_q    <= '0;
      read_data_q    <= '0;
      load_valid_q   <= 1'b0;
      misalign_err_q <= 1'b0;
      size_q         <= SZ_B;
      offset_q       <= 2'b00;
      zext_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_be_q       <= bus_be_d;
      bus_wdata_q    <= bus_wdata_d;
      read_data_q    <= read_data_d;
      load_valid_q   <= load_valid_d;
      misalign_err_q <= misalign_err_d;
      size_q         <= size_d;
      offset_q       <= offset_d;
      zext_q         <= zext_d;
    end
  end

  assign Stall       = ((state_q == IDLE) & req) | (state_q == REQ);
  assign LoadValid   = load_valid_q;
  assign ReadData    = read_data_q;
  assign MisalignErr = misalign_err_q;
  assign BusReq      = bus_req_q;
  assign BusWE       = bus_we_q;
  assign BusAddr     = bus_addr_q;
  assign BusBE       = bus_be_q;
  assign BusWData    = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference memory predicts every
// access, a word-array bus slave answers the DUT, and a monitor checks what it presents.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic        Stall, LoadValid, MisalignErr;
  logic [31:0] ReadData;
  logic        BusReq, BusWE;
  logic [31:0] BusAddr, BusWData;
  logic [3:0]  BusBE;
  logic        BusAck;
  logic [31:0] BusRData;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Funct3      (Funct3),
    .ALUResult   (ALUResult),
    .WriteData   (WriteData),
    .Stall       (Stall),
    .LoadValid   (LoadValid),
    .ReadData    (ReadData),
    .MisalignErr (MisalignErr),
    .BusReq      (BusReq),
    .BusWE       (BusWE),
    .BusAddr     (BusAddr),
    .BusBE       (BusBE),
    .BusWData    (BusWData),
    .BusAck      (BusAck),
    .BusRData    (BusRData)
  );

  typedef struct {
    bit          is_load;
    bit          trap;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  ref_mem   [0:1023];
  logic [31:0] slave_mem [0:255];
  int          total = 0;
  int          bad = 0;
  int          next_latency = 0;
  bit          stray_ack = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flagFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: unexpected event at %0t", name, $time);
  endtask

  task automatic pokeWord(input logic [31:0] addr, input logic [31:0] w);
    slave_mem[addr[9:2]] = w;
    for (int b = 0; b < 4; b++) ref_mem[{addr[9:2], 2'b00} + b] = w[8*b +: 8];
  endtask

  // Predicts one access from the memory model, launches it and waits for the stall to end.
  task automatic applyStimulus(input bit is_load, input bit both, input logic [2:0] f3,
                               input logic [31:0] ea, input logic [31:0] wd, input int latency);
    exp_t e;
    int   n, ea_i, eff, lane, cycles, exp_cycles;
    n    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ea_i = int'(ea[9:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    e.trap = (ea_i % n) != 0;
`else
    e.trap = 1'b0;
`endif
    eff       = ea_i - (ea_i % n);
    lane      = eff % 4;
    e.is_load = is_load;
    e.addr    = 32'(eff - lane);
    e.be      = 4'(((1 << n) - 1) << lane);
    e.wdata   = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
    e.rdata   = '0;
    if (is_load) begin
      for (int i = 0; i < n; i++) e.rdata |= 32'(ref_mem[eff + i]) << (8 * i);
      if (n < 4 && !f3[2] && e.rdata[8*n-1]) e.rdata |= ~((32'd1 << (8 * n)) - 32'd1);
    end else if (!e.trap) begin
      for (int i = 0; i < n; i++) ref_mem[eff + i] = wd[8*i +: 8];
    end
    exp_cycles   = e.trap ? 1 : 2 + latency;
    next_latency = latency;
    MemRead      = is_load;
    MemWrite     = !is_load || both;
    Funct3       = f3;
    ALUResult    = ea;
    WriteData    = wd;
    exp_q.push_back(e);
    cycles = 0;
    forever begin
      @(negedge clk);
      if (!Stall) break;
      cycles++;
      if (cycles >= 40) begin
        flagFail("stall_timeout");
        break;
      end
    end
    checkOutput("stall_cycles", 32'(cycles), 32'(exp_cycles));
    @(posedge clk);
    #1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Funct3    = 3'($urandom);
    ALUResult = $urandom;
    WriteData = $urandom;
  endtask

  // Abandons a load with a one-cycle reset while the bus request is outstanding.
  task automatic resetDuringReq();
    exp_t e;
    e = '{is_load: 1'b1, trap: 1'b0, addr: 32'h40, be: 4'hF, wdata: 32'h0, rdata: 32'h0};
    next_latency = 20;
    MemRead   = 1'b1;
    MemWrite  = 1'b0;
    Funct3    = 3'b010;
    ALUResult = 32'h40;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput("rst_req_busreq_before", 32'(BusReq), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    MemRead = 1'b0;
    checkOutput("rst_req_busreq_after", 32'(BusReq), 32'd0);
    exp_q.delete();
    stray_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("rst_req_no_load_valid", 32'(LoadValid), 32'd0);
      checkOutput("rst_req_no_busreq", 32'(BusReq), 32'd0);
    end
    stray_ack = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Bus slave: acks after next_latency wait cycles, and throws stray acks when idle.
  initial begin
    bit resp_active;
    int resp_wait;
    BusAck      = 1'b0;
    BusRData    = '0;
    resp_active = 1'b0;
    resp_wait   = 0;
    forever begin
      @(negedge clk);
      BusAck = 1'b0;
      if (BusReq) begin
        if (!resp_active) begin
          resp_active = 1'b1;
          resp_wait   = next_latency;
        end
        if (resp_wait == 0) begin
          BusAck = 1'b1;
          if (BusWE) begin
            for (int b = 0; b < 4; b++)
              if (BusBE[b]) slave_mem[BusAddr[9:2]][8*b +: 8] = BusWData[8*b +: 8];
          end else begin
            BusRData = slave_mem[BusAddr[9:2]];
          end
          resp_active = 1'b0;
        end else begin
          resp_wait--;
          BusRData = $urandom;
        end
      end else begin
        resp_active = 1'b0;
        if (stray_ack || $urandom_range(0, 3) == 0) begin
          BusAck   = 1'b1;
          BusRData = $urandom;
        end
      end
    end
  end

  // Monitor: checks bus fields while a request is up and pops results as they appear.
  initial begin
    exp_t e;
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (BusReq) begin
          if (exp_q.size() == 0) flagFail("bus_unexpected");
          else begin
            e = exp_q[0];
            if (e.trap) flagFail("bus_on_misalign");
            else begin
              checkOutput("bus_addr", BusAddr, e.addr);
              checkOutput("bus_we", 32'(BusWE), 32'(!e.is_load));
              checkOutput("bus_be", 32'(BusBE), 32'(e.be));
              if (!e.is_load) checkOutput("bus_wdata", BusWData, e.wdata);
            end
          end
        end
        if (prev_req && !BusReq) begin
          if (exp_q.size() == 0) checkOutput("abandon_load_valid", 32'(LoadValid), 32'd0);
          else begin
            e = exp_q.pop_front();
            checkOutput("load_valid", 32'(LoadValid), 32'(e.is_load));
            if (e.is_load) checkOutput("read_data", ReadData, e.rdata);
          end
        end else if (LoadValid) begin
          flagFail("load_valid_unexpected");
        end
        if (MisalignErr) begin
          if (exp_q.size() == 0) flagFail("misalign_unexpected");
          else begin
            e = exp_q.pop_front();
            checkOutput("misalign_err", 32'(MisalignErr), 32'(e.trap));
          end
        end
      end
      prev_req = BusReq;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          r_load, r_both;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wd;
    int          r_lat;
    rst_n     = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Funct3    = 3'b000;
    ALUResult = '0;
    WriteData = '0;
    for (int i = 0; i < 256; i++) pokeWord(32'(i * 4), $urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_stall", 32'(Stall), 32'd0);
    checkOutput("reset_load_valid", 32'(LoadValid), 32'd0);
    checkOutput("reset_read_data", ReadData, 32'd0);
    checkOutput("reset_misalign", 32'(MisalignErr), 32'd0);
    checkOutput("reset_bus_req", 32'(BusReq), 32'd0);
    checkOutput("reset_bus_we", 32'(BusWE), 32'd0);
    checkOutput("reset_bus_addr", BusAddr, 32'd0);
    checkOutput("reset_bus_be", 32'(BusBE), 32'd0);
    checkOutput("reset_bus_wdata", BusWData, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    pokeWord(32'h100, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0);
    pokeWord(32'h100, 32'h80FF0000);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0);
    applyStimulus(1'b0, 1'b0, 3'b001, 32'h202, 32'h1234ABCD, 1);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 2);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h300, 32'hCAFEF00D, 3);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h101, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0);
    resetDuringReq();

    for (int k = 0; k < 200; k++) begin
      r_load = 1'($urandom_range(0, 1));
      r_both = r_load && ($urandom_range(0, 3) == 0);
      r_f3   = r_load ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
      r_addr = 32'($urandom_range(0, 1023));
      r_wd   = $urandom;
      r_lat  = $urandom_range(0, 3);
      applyStimulus(r_load, r_both, r_f3, r_addr, r_wd, r_lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
